// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential binary-to-BCD converter (shift-add-3).
//
// A value captured on an accepted start is shifted MSB-first into a BCD
// accumulator over W clocks. Before each shift, any digit >= 5 gets +3, so
// the doubling caused by the shift carries correctly into the next digit.
// Values above 9999 saturate to 9999 and raise ovf.
//
// Ports
//   clk    in   1     clock, rising edge
//   rst_n  in   1     synchronous active-low reset
//   start  in   1     conversion request, sampled only while idle
//   din    in   W     unsigned binary value, captured on accepted start
//   busy   out  1     conversion in progress
//   done   out  1     one-cycle pulse when dout/ovf/lz update
//   dout   out  4*ND  packed BCD result, digit 0 (units) in [3:0]
//   ovf    out  1     captured value exceeded 9999 (result saturated)
//   lz     out  ND    leading-zero blank mask, bit 0 always 0

// Per-digit correction: +3 when the digit is 5..9.
module bin2bcd_seq_dig (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

module bin2bcd_seq #(
  parameter int W  = 14,
  parameter int ND = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    din,
  output logic            busy,
  output logic            done,
  output logic [4*ND-1:0] dout,
  output logic            ovf,
  output logic [ND-1:0]   lz
);

  localparam int BW = 4*ND;
  localparam int CW = $clog2(W+1);

  typedef enum logic {S_IDLE, S_CONV} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sat_q, sat_d;
  logic            done_q, done_d;
  logic [BW-1:0]   dout_q, dout_d;
  logic            ovf_q, ovf_d;
  logic [ND-1:0]   lz_q, lz_d;

  // Digit correction, one instance per BCD digit.
  logic [ND-1:0][3:0] acc_adj;
  logic [BW-1:0]      adj_flat;
  logic [BW-1:0]      acc_shift;
  logic [BW-1:0]      final_res;
  logic [ND-1:0]      lz_nx;
  logic               last;

  for (genvar g = 0; g < ND; g++) begin : g_dig
    bin2bcd_seq_dig u_dig (
      .d_i (acc_q[4*g +: 4]),
      .d_o (acc_adj[g])
    );
  end

  assign adj_flat  = acc_adj;
  assign acc_shift = {adj_flat[BW-2:0], sr_q[W-1]};
  // Saturation overrides the accumulator: bits shifted out of the top digit
  // are lost, but the corrected digits themselves stay in 0..9.
  assign final_res = sat_q ? {ND{4'h9}} : acc_shift;
  assign last      = (cnt_q == CW'(1));

  // Leading-zero mask: a running AND of "digit is zero" from the top down.
  always_comb begin
    logic run;
    lz_nx = '0;
    run   = 1'b1;
    for (int i = ND-1; i >= 1; i--) begin
      run      = run & (final_res[4*i +: 4] == 4'd0);
      lz_nx[i] = run;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    lz_d    = lz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = din;
          acc_d   = '0;
          cnt_d   = CW'(W);
          sat_d   = (32'(din) > 32'd9999);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        sr_d  = {sr_q[W-2:0], 1'b0};
        acc_d = acc_shift;
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          dout_d  = final_res;
          ovf_d   = sat_q;
          lz_d    = lz_nx;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      lz_q    <= {{(ND-1){1'b1}}, 1'b0};
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      lz_q    <= lz_d;
    end
  end

  assign busy = (state_q == S_CONV);
  assign done = done_q;
  assign dout = dout_q;
  assign ovf  = ovf_q;
  assign lz   = lz_q;

endmodule
